axi_ame_rd: RTL and testbench

- AXI4 burst-read master engine for the AME subsystem; the read-side counterpart of the AME write path.
- Fetches a contiguous block of 32-bit words from memory into an internal FIFO and presents them on a valid/ready stream to AME compute logic.
- Splits each command into INCR bursts limited by MAX_BURST and by 4 KB boundaries.
- Uses FIFO credit flow control, so R beats are never stalled by the downstream consumer.

---
 rtl/axi_ame_rd.sv | 172 +++++++++++++++++
 tb/tb_axi_ame_rd.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ame_rd.sv
// axi_ame_rd: AXI4 INCR burst-read engine that fetches a contiguous word block
// into a credit-managed FIFO and streams it to AME compute logic.
module axi_ame_rd #(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_areset,
    input  logic        cmd_start,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arlock,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic [3:0]  m_axi_arqos,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        ame_rd_run,
    output logic        ame_rd_done,
    output logic        ame_rd_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [16:0] MAXB = 17'(MAX_BURST);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, FLUSH} state_e;

    state_e state_q, state_d;
    logic [31:0] addr_q, addr_d, raddr_q, raddr_d;
    logic [15:0] req_q, req_d, rrem_q, rrem_d;
    logic [16:0] beat_q, beat_d, ar_blen, r_blen;
    logic [AW:0] out_q, out_d, cnt_q, cnt_d, free;
    logic [AW-1:0] wp_q, rp_q;
    logic run_q, run_d, done_q, done_d, err_q, err_d, en_q;
    logic r_end, r_cmd_last, push, pop, ar_hs, fin;
    logic unused_lsb;
    logic [32:0] mem [FIFO_DEPTH];

    // The split depends only on address and words left, so the R side replays
    // it to know where every rlast and the final command word must fall.
    function automatic logic [16:0] burst_len(input logic [9:0] w, input logic [15:0] rem);
        logic [16:0] page, m;
        page = 17'(11'd1024 - {1'b0, w});
        m = ({1'b0, rem} < MAXB) ? {1'b0, rem} : MAXB;
        return (page < m) ? page : m;
    endfunction

    assign ar_blen = burst_len(addr_q[11:2], req_q);
    assign r_blen = burst_len(raddr_q[11:2], rrem_q);
    assign free = DEPTH - cnt_q - out_q;
    assign m_axi_arvalid = (state_q == ADDR) && ({{(16 - AW){1'b0}}, free} >= ar_blen);
    assign m_axi_araddr = (state_q == ADDR) ? addr_q : '0;
    assign m_axi_arlen = (state_q == ADDR) ? 8'(ar_blen - 17'd1) : '0;
    assign m_axi_arsize = 3'd2;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot = 3'd0;
    assign m_axi_arqos = 4'd0;
    assign m_axi_rready = en_q && (cnt_q != DEPTH);
    assign rd_valid = cnt_q != '0;
    assign rd_data = rd_valid ? mem[rp_q][31:0] : '0;
    assign rd_last = rd_valid && mem[rp_q][32];
    assign push = m_axi_rvalid && m_axi_rready;
    assign pop = rd_valid && rd_ready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign fin = pop && rd_last && (state_q == WAIT || state_q == FLUSH);
    assign r_end = (beat_q + 17'd1) == r_blen;
    assign r_cmd_last = r_end && ({1'b0, rrem_q} == r_blen);
    assign ame_rd_run = run_q;
    assign ame_rd_done = done_q;
    assign ame_rd_error = err_q;
    assign unused_lsb = ^cmd_addr[1:0];

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        req_d = req_q;
        raddr_d = raddr_q;
        rrem_d = rrem_q;
        beat_d = beat_q;
        run_d = run_q;
        err_d = err_q;
        done_d = 1'b0;
        out_d = out_q + (ar_hs ? ar_blen[AW:0] : '0) - (AW + 1)'(push);
        cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (push) begin
            err_d = err_q || (m_axi_rresp != 2'b00) || (m_axi_rlast != r_end) || (rrem_q == '0);
            beat_d = r_end ? '0 : beat_q + 17'd1;
            raddr_d = r_end ? raddr_q + {13'd0, r_blen, 2'b00} : raddr_q;
            rrem_d = r_end ? rrem_q - r_blen[15:0] : rrem_q;
        end
        case (state_q)
            IDLE: begin
                if (cmd_start && cmd_len == '0) done_d = 1'b1;
                else if (cmd_start) begin
                    addr_d = {cmd_addr[31:2], 2'b00};
                    raddr_d = {cmd_addr[31:2], 2'b00};
                    req_d = cmd_len;
                    rrem_d = cmd_len;
                    beat_d = '0;
                    err_d = 1'b0;
                    run_d = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: if (ar_hs) begin
                addr_d = addr_q + {13'd0, ar_blen, 2'b00};
                req_d = req_q - ar_blen[15:0];
                state_d = ({1'b0, req_q} == ar_blen) ? WAIT : ADDR;
            end
            WAIT: state_d = (rrem_q == '0) ? FLUSH : WAIT;
            default: ;
        endcase
        if (fin) begin
            state_d = IDLE;
            run_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q <= IDLE;
            addr_q <= '0;
            raddr_q <= '0;
            req_q <= '0;
            rrem_q <= '0;
            beat_q <= '0;
            out_q <= '0;
            cnt_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
            run_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            raddr_q <= raddr_d;
            req_q <= req_d;
            rrem_q <= rrem_d;
            beat_q <= beat_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
            wp_q <= wp_q + AW'(push);
            rp_q <= rp_q + AW'(pop);
            run_q <= run_d;
            done_q <= done_d;
            err_q <= err_d;
            en_q <= 1'b1;
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (push) mem[wp_q] <= {r_cmd_last, m_axi_rdata};
    end
endmodule

// File: tb/tb_axi_ame_rd.sv
// tb_axi_ame_rd: randomized AXI read slave and stream sink around axi_ame_rd,
// checked against queues of expected bursts and words built from the command.
module tb_axi_ame_rd;
    logic clk = 1'b0, rst = 1'b1;
    logic cmd_start = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic [31:0] araddr, rdata = '0, rd_data;
    logic [7:0] arlen;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst, rresp = '0;
    logic [3:0] arcache, arqos;
    logic arlock, arvalid, rready, rd_last, rd_valid, run, done, err;
    logic arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rd_ready = 1'b0;
    int n_cmp = 0, n_bad = 0;
    logic [39:0] exp_ar[$];
    logic [32:0] exp_w[$];
    logic [32:0] rq[$];
    int acc = 0, popped = 0, done_cnt = 0, d_base = 0, ar_cnt = 0;
    int beat_idx = 0, err_beat = -1, rd_mode = 0;
    bit fast = 1'b1;
    logic ar_pend = 1'b0;
    logic [39:0] pend_ar = '0;

    axi_ame_rd dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ame_rd_run(run), .ame_rd_done(done), .ame_rd_error(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave, sink and invariant monitor: inputs change only on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            arready = 1'b0;
            rvalid = 1'b0;
            rd_ready = 1'b0;
            ar_pend = 1'b0;
        end else begin
            if (ar_pend) chk("ar_hold", 64'({arvalid, araddr, arlen}), 64'({1'b1, pend_ar}));
            chk("credit_bound", 64'(acc - popped <= 64), 64'd1);
            if (arvalid) chk("ar_credit", 64'(64 - (acc - popped) >= int'(arlen) + 1), 64'd1);
            if (done) begin
                done_cnt++;
                chk("run_at_done", 64'(run), 64'd0);
            end
            if (rq.size() > 0 && (fast || $urandom_range(0, 3) != 0)) begin
                rvalid = 1'b1;
                rdata = memw(rq[0][31:0]);
                rlast = rq[0][32];
                rresp = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                chk("rready", 64'(rready), 64'd1);
                if (rready) begin
                    void'(rq.pop_front());
                    beat_idx++;
                end
            end else begin
                rvalid = 1'b0;
                rlast = 1'b0;
                rresp = 2'b00;
            end
            arready = fast || ($urandom_range(0, 2) != 0);
            if (arvalid && arready) begin
                ar_cnt++;
                acc += int'(arlen) + 1;
                if (exp_ar.size() == 0) chk("ar_extra", 64'(arvalid), 64'd0);
                else chk("ar_addr_len", 64'({araddr, arlen}), 64'(exp_ar.pop_front()));
                for (int i = 0; i <= int'(arlen); i++)
                    rq.push_back({i == int'(arlen), araddr + 32'(4 * i)});
            end
            ar_pend = arvalid && !arready;
            pend_ar = {araddr, arlen};
            rd_ready = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (rd_valid && rd_ready) begin
                popped++;
                if (exp_w.size() == 0) chk("rd_extra", 64'(rd_valid), 64'd0);
                else chk("rd_word", 64'({rd_last, rd_data}), 64'(exp_w.pop_front()));
            end
        end
    end

    task automatic start_cmd(input logic [31:0] a, input int len, input int eb);
        logic [31:0] wa;
        int rem, n, pg;
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_addr = a;
        cmd_len = 16'(len);
        wa = a & 32'hFFFF_FFFC;
        rem = len;
        while (rem > 0) begin
            pg = (4096 - int'(wa[11:0])) / 4;
            n = (rem < 16) ? rem : 16;
            if (pg < n) n = pg;
            exp_ar.push_back({wa, 8'(n - 1)});
            wa += 32'(4 * n);
            rem -= n;
        end
        for (int i = 0; i < len; i++)
            exp_w.push_back({i == len - 1, memw((a & 32'hFFFF_FFFC) + 32'(4 * i))});
        beat_idx = 0;
        err_beat = eb;
        ar_cnt = 0;
        d_base = done_cnt;
        @(negedge clk);
        cmd_start = 1'b0;
        if (len > 0) begin
            chk("run_up", 64'(run), 64'd1);
            chk("err_clear", 64'(err), 64'd0);
        end
    endtask

    task automatic wait_done(input logic exp_err);
        for (int c = 0; c < 5000 && done_cnt == d_base; c++) @(negedge clk);
        chk("done_timeout", 64'(done_cnt != d_base), 64'd1);
        repeat (4) @(negedge clk);
        chk("done_once", 64'(done_cnt - d_base), 64'd1);
        chk("ar_left", 64'(exp_ar.size()), 64'd0);
        chk("words_left", 64'(exp_w.size()), 64'd0);
        chk("err_flag", 64'(err), 64'(exp_err));
        chk("run_low", 64'(run), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        int rl, reb;
        #1;
        chk("rst_ar", 64'({arvalid, araddr, arlen, rready}), 64'd0);
        chk("rst_rd", 64'({rd_valid, rd_data, rd_last, run, done, err}), 64'd0);
        chk("ar_const", 64'({arsize, arburst, arlock, arcache, arprot, arqos}),
            64'({3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        start_cmd(32'h1000, 8, -1);
        wait_done(1'b0);
        chk("ar_cnt_8", 64'(ar_cnt), 64'd1);

        start_cmd(32'h2000, 40, -1);
        wait_done(1'b0);
        chk("ar_cnt_40", 64'(ar_cnt), 64'd3);

        start_cmd(32'h0FF8, 6, -1);
        wait_done(1'b0);
        chk("ar_cnt_4k", 64'(ar_cnt), 64'd2);

        rd_mode = 2;
        start_cmd(32'h3000, 128, -1);
        repeat (200) @(negedge clk);
        chk("fifo_full_fill", 64'(acc - popped), 64'd64);
        chk("ar_stall", 64'(ar_cnt), 64'd4);
        rd_mode = 1;
        wait_done(1'b0);
        chk("ar_cnt_128", 64'(ar_cnt), 64'd8);

        rd_mode = 0;
        start_cmd(32'h4000, 8, 2);
        wait_done(1'b1);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        start_cmd(32'h4100, 4, -1);
        wait_done(1'b0);

        start_cmd(32'h5000, 0, -1);
        chk("zero_done", 64'({done, run, arvalid}), 64'b100);
        @(negedge clk);
        chk("zero_after", 64'({done, run, arvalid}), 64'd0);
        chk("zero_no_ar", 64'(ar_cnt), 64'd0);

        fast = 1'b0;
        rd_mode = 1;
        for (int k = 0; k < 6; k++) begin
            ra = (32'($urandom_range(1, 14)) << 12) + 32'(4096 - 4 * $urandom_range(1, 40))
                 + 32'($urandom_range(0, 3));
            rl = int'($urandom_range(1, 90));
            reb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
            start_cmd(ra, rl, reb);
            wait_done(reb >= 0);
        end

        start_cmd(32'h6000, 100, -1);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ar", 64'({arvalid, araddr, arlen, rready}), 64'd0);
        chk("mid_rst_rd", 64'({rd_valid, rd_data, rd_last, run, done, err}), 64'd0);
        exp_ar.delete();
        exp_w.delete();
        rq.delete();
        acc = 0;
        popped = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fast = 1'b1;
        rd_mode = 0;
        start_cmd(32'h7000, 20, -1);
        wait_done(1'b0);
        chk("ar_cnt_post_rst", 64'(ar_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
